// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, load extraction/extension,
// writeback mux, misaligned-load detection and a retired-instruction counter.
// Bit numbering: vectors are declared descending here. The big-endian MSB
// (bit 0 in MSB-first numbering) is index [31] of a data word and [4] of a
// register index. Byte lane 0 is therefore bits [31:24].
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        flush,
  input  logic [31:0] nextPC_in,
  input  logic [4:0]  destReg_in,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] dataOut_in,
  input  logic        PCtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        loadSign_in,
  input  logic [1:0]  DSize_in,
  output logic        regWrite_out,
  output logic [4:0]  regDest_out,
  output logic [31:0] regData_out,
  output logic        misalign_out,
  output logic [31:0] misalignAddr_out,
  output logic [31:0] retired_out
);

  // Held MEM/WB slot
  logic        r_v;
  logic [31:0] r_next_pc;
  logic [4:0]  r_dest;
  logic [31:0] r_alu;
  logic [31:0] r_data;
  logic        r_pc_to_reg;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_load_sign;
  logic [1:0]  r_dsize;
  logic [31:0] r_retired;

  logic [1:0]  w_a;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_mis_cond;
  logic        w_misaligned;
  logic [31:0] w_wb_data;

  assign w_a = r_alu[1:0];

  // Capture the memory stage outputs; flush turns the slot into a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v          <= 1'b0;
      r_next_pc    <= 32'd0;
      r_dest       <= 5'd0;
      r_alu        <= 32'd0;
      r_data       <= 32'd0;
      r_pc_to_reg  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_load_sign  <= 1'b0;
      r_dsize      <= 2'b00;
    end else begin
      r_v          <= valid_in & ~flush;
      r_next_pc    <= nextPC_in;
      r_dest       <= destReg_in;
      r_alu        <= aluResult_in;
      r_data       <= dataOut_in;
      r_pc_to_reg  <= PCtoReg_in;
      r_reg_write  <= RegWrite_in;
      r_mem_to_reg <= MemToReg_in;
      r_load_sign  <= loadSign_in;
      r_dsize      <= DSize_in;
    end
  end

  // Select the addressed lane, extend it, and detect misalignment by size
  always_comb begin
    w_byte = r_data[31:24];
    case (w_a)
      2'b00:   w_byte = r_data[31:24];
      2'b01:   w_byte = r_data[23:16];
      2'b10:   w_byte = r_data[15:8];
      default: w_byte = r_data[7:0];
    endcase
    w_half = w_a[1] ? r_data[15:0] : r_data[31:16];
    w_load = r_data;
    w_mis_cond = 1'b0;
    case (r_dsize)
      2'b00: begin
        w_load = r_load_sign ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      2'b01: begin
        w_load = r_load_sign ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        w_mis_cond = w_a[0];
      end
      default: begin
        w_load = r_data;
        w_mis_cond = |w_a;
      end
    endcase
  end

  assign w_misaligned = r_v & r_mem_to_reg & w_mis_cond;

  // Writeback priority: link value, then load data, then ALU result
  always_comb begin
    w_wb_data = r_alu;
    if (r_pc_to_reg) begin
      w_wb_data = r_next_pc;
    end else if (r_mem_to_reg) begin
      w_wb_data = w_load;
    end
  end

  // Count every valid, non-faulting instruction leaving the pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= 32'd0;
    end else if (r_v && !w_misaligned) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign regWrite_out     = r_v & r_reg_write & ~w_misaligned & (r_dest != 5'd0);
  assign regDest_out      = r_dest;
  assign regData_out      = w_wb_data;
  assign misalign_out     = w_misaligned;
  assign misalignAddr_out = w_misaligned ? r_alu : 32'd0;
  assign retired_out      = r_retired;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage pipeline: captures the memory stage's outputs in the MEM/WB pipeline register and extracts and extends load data by size and address. It selects the writeback value and drives the register-file write port, which also serves as the forwarding source. It additionally flags misaligned loads and keeps a count of retired instructions.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and 5-bit register index.
- Bit order is [0:31] throughout; bit 0 is the MSB.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- valid_in  in  1  memory stage presents a real instruction this cycle.
- flush  in  1  discard the instruction being captured this cycle.
- nextPC_in  in  [0:31]  link value written when PCtoReg_in=1.
- destReg_in  in  [0:4]  destination register.
- aluResult_in  in  [0:31]  ALU result; also the load address.
- dataOut_in  in  [0:31]  raw data-memory word, big-endian.
- PCtoReg_in, RegWrite_in, MemToReg_in, loadSign_in  in  1 each  control bits.
- DSize_in  in  [0:1]  access size:
  - 00 = byte
  - 01 = half
  - 10 = word
  - 11 = treated as word
- regWrite_out  out  1  register-file write enable.
- regDest_out  out  [0:4]  register-file write index.
- regData_out  out  [0:31]  register-file write data, and the forwarding value.
- misalign_out  out  1  one-cycle pulse: the held load is misaligned.
- misalignAddr_out  out  [0:31]  offending address; valid while misalign_out=1.
- retired_out  out  [0:31]  count of retired instructions.

## Operation
- Pipeline register: on each clk edge, capture all *_in fields plus v = valid_in & ~flush.
  - flush forces v=0; the other fields may still load but are ignored.
- Outputs are combinational from the register contents only; there is no input-to-output combinational path.
- Load extraction, with a = held aluResult[30:31]:
  - Byte: lane a selects bits [8a : 8a+7] (a=0 gives bits [0:7]).
  - Half: a[30]=0 selects [0:15]; a[30]=1 selects [16:31].
  - Word: the full dataOut.
  - Extension: loadSign=1 sign-extends from the lane MSB; loadSign=0 zero-extends.
- Misalignment applies only when MemToReg=1:
  - half with a[31]=1;
  - word (or size 11) with a≠00.
  - misaligned = v & MemToReg & condition.
- Writeback data priority: PCtoReg → nextPC; else MemToReg → extracted load; else aluResult.
- regWrite_out = v & RegWrite & ~misaligned & (destReg≠0). Writes to r0 are always suppressed.
- regDest_out and regData_out always show the held values. Consumers qualify them with regWrite_out.
- misalign_out = misaligned; misalignAddr_out = held aluResult when misaligned, else 0.
- Retire counter:
  - Increments by 1 on each edge where the held slot has v=1 and misaligned=0, whether or not it writes a register (stores and branches count).
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Latency is one cycle: an instruction presented at edge N appears on the write port during cycle N..N+1. The register file writes it at edge N+1.
- Throughput is one instruction per cycle. There are no stalls inside this block; upstream stalls arrive as valid_in=0 (bubble).
- A flush and a valid instruction in the same cycle produce a bubble.
- Reset (reset=0, asynchronous) forces:
  - v=0 and every held field to 0;
  - regWrite_out=0, regDest_out=0, regData_out=0, misalign_out=0, misalignAddr_out=0, retired_out=0.
- Reset asserted mid-stream discards the held instruction; it is neither written nor counted.
- Reset deassertion is synchronised outside this block. The first capture occurs at the first rising edge with reset=1.
- misalign_out lasts exactly one cycle per offending instruction. Back-to-back misaligned loads give a continuous high level with the address updating each cycle.

## Test plan
- Reset then ALU op: valid_in=1, RegWrite=1, destReg=5, aluResult=0x12345678 → next cycle regWrite_out=1, regDest_out=5, regData_out=0x12345678, retired_out=1.
- Byte loads with dataOut=0x11A2B3F4:
  - a=01, loadSign=1 → 0xFFFFFFA2;
  - a=11, loadSign=0 → 0x000000F4.
- Half/misalign:
  - half load, a=10, loadSign=1, dataOut=0x0000_8001 → 0xFFFF8001;
  - half load, addr=0x1003 → regWrite_out=0, misalign_out=1 for one cycle, misalignAddr_out=0x1003, retired_out unchanged.
- Link and r0:
  - PCtoReg=1, nextPC=0x400, destReg=31, MemToReg=1 → regData_out=0x400;
  - ALU write to destReg=0 → regWrite_out=0, retired_out increments.
- Flush and bubbles: valid_in=1 with flush=1, then valid_in=0 → regWrite_out=0 both cycles, retired_out constant.
- Async reset mid-stream:
  - reset=0 between edges → all outputs 0 immediately;
  - preload the counter to 0xFFFFFFFF via 2^32−1 retirements (or a force) and retire one more → 0.
